// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network output stage.
// Holds the score width rule, class index width, argmax state encoding
// and the signed score type at the default feature width.
package nn_pkg;

  localparam int CLS_IDX_W = 4;

  // Score width grows 16 bits beyond the network feature width.
  function automatic int score_w(input int feature_wide);
    return feature_wide + 16;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } argmax_state_e;

  localparam int SCORE_W_DEF = score_w(7);
  typedef logic signed [SCORE_W_DEF-1:0] score_t;

endpackage

// File: rtl/nn_top2_tracker.sv
// Running best (and, with NN_ARGMAX_CONF_MARGIN_EN, second-best) score tracker.
// Ports: i_first/i_beat mark an accepted beat (first of frame or not), i_idx is
// its class index, i_clear drops state; o_res_* show the result including the
// current beat, o_low_conf flags a top-two gap (or threshold distance) below MARGIN.
module nn_top2_tracker
  import nn_pkg::*;
#(
  parameter int                         CLASS_NUM = 1,
  parameter int                         SCORE_W   = 23,
  parameter logic signed [SCORE_W-1:0]  THRESH    = '0,
  parameter logic        [SCORE_W-1:0]  MARGIN    = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clear,
  input  logic                        i_first,
  input  logic                        i_beat,
  input  logic [CLS_IDX_W-1:0]        i_idx,
  input  logic signed [SCORE_W-1:0]   i_score,
  output logic signed [SCORE_W-1:0]   o_res_score,
  output logic [CLS_IDX_W-1:0]        o_res_idx,
  output logic                        o_low_conf
);

  logic signed [SCORE_W-1:0] r_best;
  logic signed [SCORE_W-1:0] w_nxt_best;
  logic [CLS_IDX_W-1:0]      r_idx;
  logic [CLS_IDX_W-1:0]      w_nxt_idx;
  logic                      w_gt;

  // Strictly greater only, so a tie keeps the earlier (lower) index.
  assign w_gt = i_score > r_best;

  always_comb begin
    w_nxt_best = r_best;
    w_nxt_idx  = r_idx;
    if (i_first) begin
      w_nxt_best = i_score;
      w_nxt_idx  = '0;
    end else if (w_gt) begin
      w_nxt_best = i_score;
      w_nxt_idx  = i_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_best <= '0;
      r_idx  <= '0;
    end else if (i_beat) begin
      r_best <= w_nxt_best;
      r_idx  <= w_nxt_idx;
    end
  end

  assign o_res_score = w_nxt_best;
  assign o_res_idx   = w_nxt_idx;

`ifdef NN_ARGMAX_CONF_MARGIN_EN
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  logic signed [SCORE_W-1:0] r_second;
  logic signed [SCORE_W-1:0] w_nxt_second;
  logic signed [SCORE_W:0]   w_gap;
  logic [SCORE_W:0]          w_mag;

  // A new best demotes the old best; otherwise a larger beat displaces second.
  always_comb begin
    w_nxt_second = r_second;
    if (i_first) begin
      w_nxt_second = SCORE_MIN;
    end else if (w_gt) begin
      w_nxt_second = r_best;
    end else if (i_score > r_second) begin
      w_nxt_second = i_score;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_second <= SCORE_MIN;
    end else if (i_clear) begin
      r_second <= SCORE_MIN;
    end else if (i_beat) begin
      r_second <= w_nxt_second;
    end
  end

  // One extra bit keeps the difference exact across the full signed range.
  always_comb begin
    if (CLASS_NUM == 1) begin
      w_gap = {i_score[SCORE_W-1], i_score} - {THRESH[SCORE_W-1], THRESH};
    end else begin
      w_gap = {w_nxt_best[SCORE_W-1], w_nxt_best} - {w_nxt_second[SCORE_W-1], w_nxt_second};
    end
    w_mag = w_gap[SCORE_W] ? (~w_gap + 1'b1) : w_gap;
  end

  assign o_low_conf = w_mag < {1'b0, MARGIN};
`else
  logic w_unused;
  assign w_unused   = ^{MARGIN, THRESH, (CLASS_NUM == 1)};
  assign o_low_conf = 1'b0;
`endif

endmodule

// File: rtl/nn_argmax.sv
// Output-layer reducer: serial signed scores -> winning class index and score,
// or a binary threshold decision when CLASS_NUM==1. Optional NN_ARGMAX_CONF_MARGIN_EN
// adds a low-confidence flag. Ports: s_* score stream, m_* result handshake, flush abort.
module nn_argmax
  import nn_pkg::*;
#(
  parameter int                                         CLASS_NUM    = 1,
  parameter int                                         FEATURE_WIDE = 7,
  parameter logic signed [score_w(FEATURE_WIDE)-1:0]    THRESH       = '0,
  parameter logic        [score_w(FEATURE_WIDE)-1:0]    MARGIN       = (score_w(FEATURE_WIDE))'(64),
  localparam int                                        SCORE_W      = score_w(FEATURE_WIDE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        s_valid,
  input  logic signed [SCORE_W-1:0]   s_score,
  output logic                        s_ready,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [CLS_IDX_W-1:0]        m_class,
  output logic signed [SCORE_W-1:0]   m_score,
  output logic                        m_low_conf
);

  localparam logic [CLS_IDX_W-1:0] LAST_IDX = CLS_IDX_W'(CLASS_NUM - 1);

  argmax_state_e               r_state;
  logic [CLS_IDX_W-1:0]        r_cnt;
  logic                        r_s_ready;
  logic                        r_m_valid;
  logic [CLS_IDX_W-1:0]        r_m_class;
  logic signed [SCORE_W-1:0]   r_m_score;
  logic                        r_m_low_conf;

  logic                        w_accept;
  logic                        w_first;
  logic                        w_last;
  logic                        w_decision;
  logic [CLS_IDX_W-1:0]        w_res_class;
  logic signed [SCORE_W-1:0]   w_res_score;
  logic [CLS_IDX_W-1:0]        w_res_idx;
  logic                        w_low_conf;

  // flush wins: a beat presented alongside it is dropped.
  assign w_accept   = s_valid && r_s_ready && !flush;
  assign w_first    = w_accept && (r_state == IDLE);
  assign w_last     = w_accept && (((r_state == IDLE) && (CLASS_NUM == 1)) ||
                                   ((r_state == ACC) && (r_cnt == LAST_IDX)));
  assign w_decision = s_score >= THRESH;
  assign w_res_class = (CLASS_NUM == 1) ? {{(CLS_IDX_W-1){1'b0}}, w_decision} : w_res_idx;

  nn_top2_tracker #(
    .CLASS_NUM (CLASS_NUM),
    .SCORE_W   (SCORE_W),
    .THRESH    (THRESH),
    .MARGIN    (MARGIN)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (flush),
    .i_first     (w_first),
    .i_beat      (w_accept),
    .i_idx       (r_cnt),
    .i_score     (s_score),
    .o_res_score (w_res_score),
    .o_res_idx   (w_res_idx),
    .o_low_conf  (w_low_conf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_s_ready    <= 1'b1;
      r_m_valid    <= 1'b0;
      r_m_class    <= '0;
      r_m_score    <= '0;
      r_m_low_conf <= 1'b0;
    end else if (flush) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        // Result registers load only here, so they hold steady under back-pressure.
        r_state      <= HOLD;
        r_cnt        <= '0;
        r_s_ready    <= 1'b0;
        r_m_valid    <= 1'b1;
        r_m_class    <= w_res_class;
        r_m_score    <= (CLASS_NUM == 1) ? s_score : w_res_score;
        r_m_low_conf <= w_low_conf;
      end else begin
        r_state <= ACC;
        r_cnt   <= r_cnt + 1'b1;
      end
    end else if ((r_state == HOLD) && m_ready) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_class    = r_m_class;
  assign m_score    = r_m_score;
  assign m_low_conf = r_m_low_conf;

endmodule

// File: tb/tb_nn_argmax.sv
// Directed bench for nn_argmax: a 4-class instance and a 1-class threshold instance.
// Each scenario task drives its own beats and checks results against hand-computed values.
// A summary of passed/total checks is printed at the end.
module tb_nn_argmax;
  import nn_pkg::*;

  localparam int SW = score_w(7);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_low_conf;
  score_t         a_s_score, a_m_score;
  logic [3:0]     a_m_class;
  logic           b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_low_conf;
  score_t         b_s_score, b_m_score;
  logic [3:0]     b_m_class;

  int n_pass  = 0;
  int n_total = 0;

  nn_argmax #(.CLASS_NUM(4), .FEATURE_WIDE(7)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .s_valid(a_s_valid), .s_score(a_s_score), .s_ready(a_s_ready),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_class(a_m_class),
    .m_score(a_m_score), .m_low_conf(a_m_low_conf)
  );

  nn_argmax #(.CLASS_NUM(1), .FEATURE_WIDE(7), .THRESH('0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .s_valid(b_s_valid), .s_score(b_s_score), .s_ready(b_s_ready),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_class(b_m_class),
    .m_score(b_m_score), .m_low_conf(b_m_low_conf)
  );

  // Present one beat on the selected instance until accepted (bounded).
  task automatic send(input bit sel, input int sc);
    bit done = 1'b0;
    bit rdy;
    if (sel) begin b_s_valid = 1'b1; b_s_score = SW'(sc); end
    else     begin a_s_valid = 1'b1; a_s_score = SW'(sc); end
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = sel ? b_s_ready : a_s_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    if (sel) b_s_valid = 1'b0; else a_s_valid = 1'b0;
    n_total++;
    if (!done) $display("FAIL send_accept: beat %0d got not-accepted want accepted", sc);
    else n_pass++;
  endtask

  task automatic wait_res(input bit sel);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (sel ? b_m_valid : a_m_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_total++;
    if (!ok) $display("FAIL result_timeout: got m_valid=0 want 1");
    else n_pass++;
  endtask

  task automatic ack(input bit sel);
    if (sel) b_m_ready = 1'b1; else a_m_ready = 1'b1;
    @(posedge clk); #1;
    if (sel) b_m_ready = 1'b0; else a_m_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (a_s_ready !== 1'b1) $display("FAIL rst_in_s_ready: got %b want 1", a_s_ready); else n_pass++;
    n_total++; if (a_m_valid !== 1'b0) $display("FAIL rst_in_m_valid: got %b want 0", a_m_valid); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (a_s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b want 1", a_s_ready); else n_pass++;
    n_total++; if (a_m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", a_m_valid); else n_pass++;
    n_total++; if (a_m_class !== 4'd0) $display("FAIL rst_m_class: got %0d want 0", a_m_class); else n_pass++;
    n_total++; if (a_m_score !== score_t'(0)) $display("FAIL rst_m_score: got %0d want 0", a_m_score); else n_pass++;
    n_total++; if (a_m_low_conf !== 1'b0) $display("FAIL rst_low_conf: got %b want 0", a_m_low_conf); else n_pass++;
    n_total++; if (b_s_ready !== 1'b1 || b_m_valid !== 1'b0) $display("FAIL rst_single: got rdy=%b vld=%b want 1/0", b_s_ready, b_m_valid); else n_pass++;
  endtask

  task automatic test_basic();
    a_m_ready = 1'b1;
    send(0, 5); send(0, -3); send(0, 12); send(0, 7);
    n_total++; if (a_m_valid !== 1'b1) $display("FAIL basic_latency: got m_valid=%b want 1", a_m_valid); else n_pass++;
    n_total++; if (a_m_class !== 4'd2) $display("FAIL basic_class: got %0d want 2", a_m_class); else n_pass++;
    n_total++; if (a_m_score !== score_t'(12)) $display("FAIL basic_score: got %0d want 12", a_m_score); else n_pass++;
    n_total++; if (a_s_ready !== 1'b0) $display("FAIL basic_hold_rdy: got %b want 0", a_s_ready); else n_pass++;
    @(posedge clk); #1;
    a_m_ready = 1'b0;
    n_total++; if (a_m_valid !== 1'b0) $display("FAIL basic_release_vld: got %b want 0", a_m_valid); else n_pass++;
    n_total++; if (a_s_ready !== 1'b1) $display("FAIL basic_release_rdy: got %b want 1", a_s_ready); else n_pass++;
  endtask

  task automatic test_tie();
    send(0, -9); send(0, -9); send(0, -20); send(0, -9);
    wait_res(0);
    n_total++; if (a_m_class !== 4'd0) $display("FAIL tie_class: got %0d want 0", a_m_class); else n_pass++;
    n_total++; if (a_m_score !== score_t'(-9)) $display("FAIL tie_score: got %0d want -9", a_m_score); else n_pass++;
    ack(0);
  endtask

  task automatic test_hold_stable();
    send(0, 3); send(0, 8); send(0, 1); send(0, 2);
    wait_res(0);
    a_s_valid = 1'b1; a_s_score = SW'(99);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total++; if (a_m_valid !== 1'b1) $display("FAIL hold_vld[%0d]: got %b want 1", i, a_m_valid); else n_pass++;
      n_total++; if (a_m_class !== 4'd1) $display("FAIL hold_class[%0d]: got %0d want 1", i, a_m_class); else n_pass++;
      n_total++; if (a_m_score !== score_t'(8)) $display("FAIL hold_score[%0d]: got %0d want 8", i, a_m_score); else n_pass++;
      n_total++; if (a_s_ready !== 1'b0) $display("FAIL hold_rdy[%0d]: got %b want 0", i, a_s_ready); else n_pass++;
    end
    ack(0);
    n_total++; if (a_m_valid !== 1'b0) $display("FAIL hold_drop_vld: got %b want 0", a_m_valid); else n_pass++;
    // The held beat 99 must now open the next frame.
    send(0, 99); send(0, 1); send(0, 2); send(0, 3);
    wait_res(0);
    n_total++; if (a_m_class !== 4'd0) $display("FAIL hold_next_class: got %0d want 0", a_m_class); else n_pass++;
    n_total++; if (a_m_score !== score_t'(99)) $display("FAIL hold_next_score: got %0d want 99", a_m_score); else n_pass++;
    ack(0);
  endtask

  task automatic test_flush();
    send(0, 50); send(0, 60);
    a_flush = 1'b1; a_s_valid = 1'b1; a_s_score = SW'(70);
    @(posedge clk); #1;
    a_flush = 1'b0; a_s_valid = 1'b0;
    n_total++; if (a_s_ready !== 1'b1 || a_m_valid !== 1'b0) $display("FAIL flush_state: got rdy=%b vld=%b want 1/0", a_s_ready, a_m_valid); else n_pass++;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    wait_res(0);
    n_total++; if (a_m_class !== 4'd3) $display("FAIL flush_class: got %0d want 3", a_m_class); else n_pass++;
    n_total++; if (a_m_score !== score_t'(4)) $display("FAIL flush_score: got %0d want 4", a_m_score); else n_pass++;
    // Flush while a result is held drops it.
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    n_total++; if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) $display("FAIL flush_hold: got vld=%b rdy=%b want 0/1", a_m_valid, a_s_ready); else n_pass++;
  endtask

  task automatic test_single();
    bit exp_lc;
`ifdef NN_ARGMAX_CONF_MARGIN_EN
    exp_lc = 1'b1;
`else
    exp_lc = 1'b0;
`endif
    send(1, -1);
    wait_res(1);
    n_total++; if (b_m_class !== 4'd0) $display("FAIL single_neg_class: got %0d want 0", b_m_class); else n_pass++;
    n_total++; if (b_m_score !== score_t'(-1)) $display("FAIL single_neg_score: got %0d want -1", b_m_score); else n_pass++;
    n_total++; if (b_m_low_conf !== exp_lc) $display("FAIL single_neg_lc: got %b want %b", b_m_low_conf, exp_lc); else n_pass++;
    ack(1);
    send(1, 0);
    wait_res(1);
    n_total++; if (b_m_class !== 4'd1) $display("FAIL single_zero_class: got %0d want 1", b_m_class); else n_pass++;
    n_total++; if (b_m_score !== score_t'(0)) $display("FAIL single_zero_score: got %0d want 0", b_m_score); else n_pass++;
    ack(1);
    send(1, 100);
    wait_res(1);
    n_total++; if (b_m_class !== 4'd1) $display("FAIL single_big_class: got %0d want 1", b_m_class); else n_pass++;
    n_total++; if (b_m_low_conf !== 1'b0) $display("FAIL single_big_lc: got %b want 0", b_m_low_conf); else n_pass++;
    ack(1);
  endtask

  task automatic test_margin();
    bit exp_lc;
`ifdef NN_ARGMAX_CONF_MARGIN_EN
    exp_lc = 1'b1;
`else
    exp_lc = 1'b0;
`endif
    send(0, 100); send(0, 140); send(0, 30); send(0, 0);
    wait_res(0);
    n_total++; if (a_m_class !== 4'd1) $display("FAIL margin_close_class: got %0d want 1", a_m_class); else n_pass++;
    n_total++; if (a_m_low_conf !== exp_lc) $display("FAIL margin_close_lc: got %b want %b", a_m_low_conf, exp_lc); else n_pass++;
    ack(0);
    send(0, 100); send(0, 200); send(0, 30); send(0, 0);
    wait_res(0);
    n_total++; if (a_m_score !== score_t'(200)) $display("FAIL margin_wide_score: got %0d want 200", a_m_score); else n_pass++;
    n_total++; if (a_m_low_conf !== 1'b0) $display("FAIL margin_wide_lc: got %b want 0", a_m_low_conf); else n_pass++;
    ack(0);
  endtask

  initial begin
    a_flush = 1'b0; a_s_valid = 1'b0; a_s_score = '0; a_m_ready = 1'b0;
    b_flush = 1'b0; b_s_valid = 1'b0; b_s_score = '0; b_m_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_hold_stable();
    test_flush();
    test_single();
    test_margin();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nn_argmax.md
Name: nn_argmax

Overview:
- Downstream stage of the neural-network top.
- Consumes the serial stream of signed output-layer scores, one per output neuron per frame, and reduces it to a winning class index plus its score.
- Presents the result on a valid/ready handshake and back-pressures the score stream while a result is held.
- For single-output networks it performs binary thresholding instead of argmax.

Parameters:
- CLASS_NUM, 1, scores per frame (output neurons), 1..16.
- FEATURE_WIDE, 7, feature integer width of the network; sets score width.
- SCORE_W, FEATURE_WIDE+16, signed score width, derived; not overridden independently.
- THRESH, 0, signed SCORE_W-bit decision threshold, used only when CLASS_NUM==1.
- MARGIN, 64, unsigned SCORE_W-bit confidence margin (CONF_MARGIN_EN only).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort of partial frame/held result.
- s_valid  input  1  score beat valid.
- s_score  input  SCORE_W  signed score, class order 0..CLASS_NUM-1.
- s_ready  output  1  block accepts a beat.
- m_valid  output  1  result valid.
- m_ready  input  1  result consumer ready.
- m_class  output  4  winning class index (or binary decision).
- m_score  output  SCORE_W  winning signed score.
- m_low_conf  output  1  top-two margin below MARGIN.

Behaviour:
- Reset values: s_ready=1, m_valid=0, m_class=0, m_score=0, m_low_conf=0, beat counter=0, state=IDLE.
- A beat is accepted when s_valid&&s_ready. Beats need not be on consecutive cycles.
- States:
  - IDLE: first accepted beat loads best=s_score, idx=0, cnt=1, then goes to ACC. If CLASS_NUM==1, goes directly to HOLD.
  - ACC: each accepted beat compares signed s_score against best.
    - Strictly greater replaces best and idx=cnt; ties keep the lower index.
    - cnt increments on every accepted beat.
    - The beat with cnt==CLASS_NUM-1 transitions to HOLD.
  - HOLD: m_valid=1 and s_ready=0. m_valid&&m_ready returns to IDLE; s_ready rises the following cycle.
- Latency: last beat accepted at edge t, so m_valid is high after t+1. Outputs stay stable while m_valid&&!m_ready.
- m_class, m_score and m_low_conf are registered, updated only on entry to HOLD.
- CLASS_NUM==1: m_class = (s_score >= THRESH) ? 1 : 0 (signed compare); m_score = s_score.
- All comparisons are signed two's complement over SCORE_W bits; no saturation needed.
- flush: next edge forces IDLE, cnt=0, m_valid=0, s_ready=1. A beat presented with flush is discarded. flush has priority over all handshakes.
- A beat arriving in HOLD is not accepted (s_ready=0); the upstream holds it.
- Counter wraps to 0 on every transition to IDLE. It never exceeds CLASS_NUM-1.
- Asynchronous reset mid-frame discards all partial state.

Optional Feature:
- Macro: NN_ARGMAX_CONF_MARGIN_EN.
- With the macro defined:
  - The block also tracks the second-best score. A new best demotes the old best to second; otherwise a beat greater than second replaces second.
  - On entry to HOLD, m_low_conf = ((best - second) computed in SCORE_W+1 bits) < MARGIN.
  - CLASS_NUM==1: margin is |s_score - THRESH| < MARGIN.
- Without the macro: no second-best register; m_low_conf is tied 0.

Decomposition:
- Shared package nn_pkg holds:
  - score width function (FEATURE_WIDE+16),
  - CLS_IDX_W=4,
  - argmax state enumeration (IDLE/ACC/HOLD),
  - signed score typedef.
- One sub-module: nn_top2_tracker. It holds the best/second registers, the index and the compare logic. The parent owns the FSM, counter, handshake and flush.

Test Plan:
- CLASS_NUM=4, scores {5,-3,12,7}, m_ready=1 -> m_class=2, m_score=12, m_valid one cycle after beat 3, then s_ready=1 the next cycle.
- CLASS_NUM=4, scores {-9,-9,-20,-9} -> tie keeps lowest index: m_class=0, m_score=-9.
- CLASS_NUM=4, m_ready=0 for 5 cycles after result -> m_valid, m_class, m_score stable and s_ready=0 throughout; a beat presented during HOLD is not consumed.
- CLASS_NUM=4, flush after 2 beats, then {1,2,3,4} -> m_class=3, m_score=4; no residue from the aborted frame.
- CLASS_NUM=1, THRESH=0: s_score=-1 -> m_class=0; s_score=0 -> m_class=1.
- With NN_ARGMAX_CONF_MARGIN_EN, MARGIN=64:
  - {100,140,30,0} -> m_class=1, m_low_conf=1 (margin 40).
  - {100,200,30,0} -> m_low_conf=0.
